// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-only UART with a write FIFO in front of the serializer.
// Frames are start bit, DATA_WIDTH data bits sent LSB first, an optional
// parity bit, then STOP_BITS stop bits. Each bit lasts baud_div_i+1 clocks.
// The divisor is captured when a frame starts, so changing it mid-frame
// has no effect on that frame.
module uart_tx_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int DIV_WIDTH   = 16,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                          sys_clk_i,
   input  logic                          sys_rst_i,
   input  logic [DIV_WIDTH-1:0]          baud_div_i,
   input  logic                          uart_wr_i,
   input  logic [DATA_WIDTH-1:0]         uart_dat_i,
   output logic                          uart_full_o,
   output logic                          uart_empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
   output logic                          uart_ovf_o,
   output logic                          uart_busy,
   output logic                          uart_tx
);

   localparam int ADDR_WIDTH    = $clog2(FIFO_DEPTH);
   localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH);

   localparam logic [ADDR_WIDTH:0]    FULL_LEVEL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic                   LAST_STOP  = (STOP_BITS == 2);
   localparam logic                   ODD_PARITY = (PARITY_MODE == 2);
   localparam logic                   HAS_PARITY = (PARITY_MODE != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level_q;
   logic                  ovf_q;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  push;
   logic                  pop;

   // Serializer state
   tx_state_t              state;
   logic [DIV_WIDTH-1:0]   baud_cnt;
   logic [DIV_WIDTH-1:0]   div_q;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic                   parity_q;
   logic [BIT_CNT_WIDTH-1:0] bit_cnt;
   logic                   stop_cnt;
   logic                   tx_q;
   logic                   bit_done;
   logic                   stop_last;
   logic                   line_value;

   // Status flags come straight from the level register, so the write strobe
   // never reaches them combinationally.
   assign uart_full_o  = (level_q == FULL_LEVEL);
   assign uart_empty_o = (level_q == '0);
   assign uart_level_o = level_q;
   assign uart_ovf_o   = ovf_q;
   assign uart_busy    = (state != IDLE) || !uart_empty_o;
   assign uart_tx      = tx_q;

   assign fifo_head = fifo_mem[rd_ptr];
   assign push      = uart_wr_i && !uart_full_o;
   assign bit_done  = (baud_cnt == div_q);
   assign stop_last = (stop_cnt == LAST_STOP);

   // A new frame is pulled from the FIFO either from idle or at the very end
   // of the last stop bit, which keeps back-to-back frames gap-free.
   assign pop = !uart_empty_o &&
                ((state == IDLE) || ((state == STOP) && bit_done && stop_last));

   // Line level implied by the current serializer state; registered below.
   always_comb begin
      line_value = 1'b1;
      case (state)
         START:   line_value = 1'b0;
         DATA:    line_value = shift_q[0];
         PARITY:  line_value = parity_q;
         default: line_value = 1'b1;
      endcase
   end

   // FIFO data array; contents need no reset because level gates every read.
   always_ff @(posedge sys_clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= uart_dat_i;
      end
   end

   // FIFO pointers, occupancy and sticky overflow. A write against a full
   // FIFO is dropped even when a pop frees a slot on the same edge.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (!push && pop) begin
            level_q <= level_q - 1'b1;
         end
         if (uart_wr_i && uart_full_o) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Frame sequencer: walks START, DATA, PARITY, STOP with one bit period per
   // step and keeps the serial line in a register.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         state    <= IDLE;
         baud_cnt <= '0;
         div_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_q <= line_value;
         case (state)
            IDLE: begin
               if (pop) begin
                  shift_q  <= fifo_head;
                  parity_q <= (^fifo_head) ^ ODD_PARITY;
                  div_q    <= baud_div_i;
                  baud_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  shift_q  <= shift_q >> 1;
                  if (bit_cnt == LAST_BIT) begin
                     stop_cnt <= 1'b0;
                     state    <= HAS_PARITY ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (stop_last) begin
                     if (pop) begin
                        shift_q  <= fifo_head;
                        parity_q <= (^fifo_head) ^ ODD_PARITY;
                        div_q    <= baud_div_i;
                        state    <= START;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three differently configured transmitters share one stimulus
// stream; a timing-level model predicts every output on every cycle, and a few
// directed frames pin the model to hand-derived waveforms.
module tb_uart_tx_fifo;

   localparam int NI = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr    = 1'b0;
   logic [7:0]  dat   = 8'h00;
   logic [15:0] baud  = 16'd3;

   logic tx_w    [NI];
   logic full_w  [NI];
   logic empty_w [NI];
   logic ovf_w   [NI];
   logic busy_w  [NI];
   logic [4:0] lvl0;
   logic [2:0] lvl1;
   logic [3:0] lvl2;
   int         lvl_w [NI];

   int total = 0;
   int bad   = 0;

   // Model state: FIFO as a circular array, plus the start edge and divisor of
   // the frame currently on the line.
   logic [7:0] m_mem [NI][16];
   int   m_cnt   [NI];
   int   m_head  [NI];
   int   m_start [NI];
   int   m_div   [NI];
   logic [7:0] m_data [NI];
   bit   m_frame [NI];
   bit   m_ovf   [NI];
   bit   e_tx    [NI];
   int   edge_no = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .baud_div_i(baud), .uart_wr_i(wr), .uart_dat_i(dat),
      .uart_full_o(full_w[0]), .uart_empty_o(empty_w[0]), .uart_level_o(lvl0),
      .uart_ovf_o(ovf_w[0]), .uart_busy(busy_w[0]), .uart_tx(tx_w[0]));

   uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16), .PARITY_MODE(1), .STOP_BITS(2)) dut1 (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .baud_div_i(baud), .uart_wr_i(wr), .uart_dat_i(dat),
      .uart_full_o(full_w[1]), .uart_empty_o(empty_w[1]), .uart_level_o(lvl1),
      .uart_ovf_o(ovf_w[1]), .uart_busy(busy_w[1]), .uart_tx(tx_w[1]));

   uart_tx_fifo #(.DATA_WIDTH(5), .FIFO_DEPTH(8), .DIV_WIDTH(16), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .baud_div_i(baud), .uart_wr_i(wr), .uart_dat_i(dat[4:0]),
      .uart_full_o(full_w[2]), .uart_empty_o(empty_w[2]), .uart_level_o(lvl2),
      .uart_ovf_o(ovf_w[2]), .uart_busy(busy_w[2]), .uart_tx(tx_w[2]));

   // Gather the differently sized level outputs into one comparable array.
   always_comb begin
      lvl_w[0] = int'(lvl0);
      lvl_w[1] = int'(lvl1);
      lvl_w[2] = int'(lvl2);
   end

   function automatic int dw_of(int i);
      return (i == 2) ? 5 : 8;
   endfunction

   function automatic int depth_of(int i);
      return (i == 0) ? 16 : ((i == 1) ? 4 : 8);
   endfunction

   function automatic int pm_of(int i);
      return i;
   endfunction

   function automatic int sb_of(int i);
      return (i == 1) ? 2 : 1;
   endfunction

   function automatic int nbits_of(int i);
      return 1 + dw_of(i) + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i);
   endfunction

   function automatic logic [7:0] mask_of(int i);
      return 8'((1 << dw_of(i)) - 1);
   endfunction

   // Bit number idx of a frame carrying d: start, data LSB first, parity, stops.
   function automatic logic frame_bit(int i, logic [7:0] d, int idx);
      logic [7:0] v;
      v = d & mask_of(i);
      if (idx == 0) return 1'b0;
      if (idx <= dw_of(i)) return v[3'(idx - 1)];
      if ((pm_of(i) != 0) && (idx == dw_of(i) + 1)) return (^v) ^ (pm_of(i) == 2);
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic w, input logic [7:0] d);
      @(negedge clk);
      wr  = w;
      dat = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      wr    = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("rst_tx%0d", i), int'(tx_w[i]), 1);
         checkOutput($sformatf("rst_level%0d", i), lvl_w[i], 0);
         checkOutput($sformatf("rst_empty%0d", i), int'(empty_w[i]), 1);
         checkOutput($sformatf("rst_full%0d", i), int'(full_w[i]), 0);
         checkOutput($sformatf("rst_ovf%0d", i), int'(ovf_w[i]), 0);
         checkOutput($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model, advanced once per clock edge from the pre-edge inputs.
   // The line shows bit (e - start - 1) / (div + 1) of the frame in flight.
   always @(posedge clk or negedge rst_n) begin
      bit full_pre;
      bit empty_pre;
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            m_cnt[i]   = 0;
            m_head[i]  = 0;
            m_frame[i] = 1'b0;
            m_ovf[i]   = 1'b0;
            e_tx[i]    = 1'b1;
         end
      end else begin
         edge_no = edge_no + 1;
         for (int i = 0; i < NI; i++) begin
            full_pre  = (m_cnt[i] == depth_of(i));
            empty_pre = (m_cnt[i] == 0);
            if (m_frame[i])
               e_tx[i] = frame_bit(i, m_data[i], (edge_no - m_start[i] - 1) / (m_div[i] + 1));
            else
               e_tx[i] = 1'b1;
            if (m_frame[i] && (edge_no == m_start[i] + nbits_of(i) * (m_div[i] + 1)))
               m_frame[i] = 1'b0;
            if (!m_frame[i] && !empty_pre) begin
               m_data[i]  = m_mem[i][m_head[i]];
               m_head[i]  = (m_head[i] + 1) % depth_of(i);
               m_cnt[i]   = m_cnt[i] - 1;
               m_frame[i] = 1'b1;
               m_start[i] = edge_no;
               m_div[i]   = int'(baud);
            end
            if (wr) begin
               if (!full_pre) begin
                  m_mem[i][(m_head[i] + m_cnt[i]) % depth_of(i)] = dat & mask_of(i);
                  m_cnt[i] = m_cnt[i] + 1;
               end else begin
                  m_ovf[i] = 1'b1;
               end
            end
         end
      end
   end

   // Compare every output of every instance against the model each cycle.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("tx%0d", i), int'(tx_w[i]), int'(e_tx[i]));
         checkOutput($sformatf("level%0d", i), lvl_w[i], m_cnt[i]);
         checkOutput($sformatf("full%0d", i), int'(full_w[i]), (m_cnt[i] == depth_of(i)) ? 1 : 0);
         checkOutput($sformatf("empty%0d", i), int'(empty_w[i]), (m_cnt[i] == 0) ? 1 : 0);
         checkOutput($sformatf("ovf%0d", i), int'(ovf_w[i]), int'(m_ovf[i]));
         checkOutput($sformatf("busy%0d", i), int'(busy_w[i]), (m_frame[i] || (m_cnt[i] != 0)) ? 1 : 0);
      end
   end

   // Directed frames with hand-derived waveforms, then a long randomized run.
   initial begin
      logic [9:0]  pat0;
      logic [11:0] pat1;
      logic [7:0]  pat2;
      logic [11:0] pat3;
      int idx;
      int b;
      int pct;
      int hold;
      pat0 = 10'b1101001010;
      pat1 = 12'b110101001010;
      pat2 = 8'b11001010;
      pat3 = 12'b110111111110;
      pct  = 30;
      hold = 0;

      // 8N1, divisor 3, one byte 0xA5
      doReset();
      baud = 16'd3;
      applyStimulus(1'b1, 8'hA5);
      tick();
      wr = 1'b0;
      for (int k = 1; k <= 44; k++) begin
         tick();
         idx = k - 2;
         checkOutput("a5_8n1_tx", int'(tx_w[0]), int'((idx >= 0 && idx < 40) ? pat0[idx / 4] : 1'b1));
         if (k == 40) checkOutput("a5_busy_in_stop", int'(busy_w[0]), 1);
         if (k == 41) checkOutput("a5_busy_fall", int'(busy_w[0]), 0);
      end

      // Divisor 0: parity even on dut1, odd on dut2
      doReset();
      baud = 16'd0;
      applyStimulus(1'b1, 8'hA5);
      tick();
      wr = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         idx = k - 2;
         checkOutput("div0_tx0", int'(tx_w[0]), int'((idx >= 0 && idx < 10) ? pat0[idx] : 1'b1));
         checkOutput("div0_even_tx1", int'(tx_w[1]), int'((idx >= 0 && idx < 12) ? pat1[idx] : 1'b1));
         checkOutput("div0_odd_tx2", int'(tx_w[2]), int'((idx >= 0 && idx < 8) ? pat2[idx] : 1'b1));
      end

      // Two stop bits, divisor 2, two 0xFF frames back to back on dut1
      doReset();
      baud = 16'd2;
      applyStimulus(1'b1, 8'hFF);
      applyStimulus(1'b1, 8'hFF);
      tick();
      wr = 1'b0;
      for (int k = 2; k <= 78; k++) begin
         tick();
         idx = k - 2;
         b   = idx / 3;
         checkOutput("two_stop_tx1", int'(tx_w[1]), int'((b / 12 < 2) ? pat3[b % 12] : 1'b1));
      end

      // Divisor 100, 18 back-to-back writes: 17 accepted, the last overflows
      doReset();
      baud = 16'd100;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i == 17) begin
            checkOutput("fill_level_pre", lvl_w[0], 16);
            checkOutput("fill_full_pre", int'(full_w[0]), 1);
            checkOutput("fill_ovf_pre", int'(ovf_w[0]), 0);
         end
         wr  = 1'b1;
         dat = 8'(i + 1);
      end
      @(negedge clk);
      wr = 1'b0;
      checkOutput("fill_level", lvl_w[0], 16);
      checkOutput("fill_full", int'(full_w[0]), 1);
      checkOutput("fill_ovf", int'(ovf_w[0]), 1);

      // Divisor 1, three bytes: contiguous frames, empty after third pop
      doReset();
      baud = 16'd1;
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h02);
      applyStimulus(1'b1, 8'h03);
      @(negedge clk);
      wr = 1'b0;
      for (int k = 3; k <= 45; k++) begin
         tick();
         if (k == 21) checkOutput("chain_stop1_tx", int'(tx_w[0]), 1);
         if (k == 22) checkOutput("chain_start2_tx", int'(tx_w[0]), 0);
         if (k == 40) checkOutput("chain_empty_pre", int'(empty_w[0]), 0);
         if (k == 41) checkOutput("chain_empty_post", int'(empty_w[0]), 1);
         if (k == 42) checkOutput("chain_start3_tx", int'(tx_w[0]), 0);
      end

      // Reset in the middle of data bit 3 with five bytes still queued
      doReset();
      baud = 16'd3;
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h00);
      @(negedge clk);
      wr = 1'b0;
      for (int k = 6; k <= 19; k++) tick();
      checkOutput("midrst_tx_before", int'(tx_w[0]), 0);
      checkOutput("midrst_level_before", lvl_w[0], 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_tx", int'(tx_w[0]), 1);
      checkOutput("midrst_level", lvl_w[0], 0);
      checkOutput("midrst_ovf", int'(ovf_w[0]), 0);
      checkOutput("midrst_busy", int'(busy_w[0]), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) tick();
      checkOutput("midrst_idle_tx", int'(tx_w[0]), 1);
      checkOutput("midrst_idle_busy", int'(busy_w[0]), 0);

      // Randomized traffic with varying load, divisor changes and resets
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c % 500 == 0) begin
            case ((c / 500) % 4)
               0:       pct = 5;
               1:       pct = 40;
               2:       pct = 95;
               default: pct = 15;
            endcase
         end
         if ($urandom_range(0, 199) == 0) baud = 16'($urandom_range(0, 3));
         if (hold > 0) begin
            hold--;
            if (hold == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 999) == 0) begin
            rst_n = 1'b0;
            hold  = int'($urandom_range(1, 3));
         end
         wr  = (int'($urandom_range(0, 99)) < pct);
         dat = 8'($urandom);
      end
      @(negedge clk);
      wr    = 1'b0;
      rst_n = 1'b1;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL provide parameter DIV_WIDTH, default 16, width of baud divisor.
REQ-004 SHALL provide parameter PARITY_MODE, default 0, 0 none / 1 even / 2 odd.
REQ-005 SHALL provide parameter STOP_BITS, default 1, stop bit count (1 or 2).
REQ-006 SHALL provide sys_clk_i  in  1  single system clock, all logic on rising edge.
REQ-007 SHALL provide sys_rst_i  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL provide baud_div_i  in  DIV_WIDTH  bit period minus one, in clocks.
REQ-009 SHALL provide uart_wr_i  in  1  write strobe, one FIFO push per high cycle.
REQ-010 SHALL provide uart_dat_i  in  DATA_WIDTH  write data.
REQ-011 SHALL provide uart_full_o  out  1  FIFO full.
REQ-012 SHALL provide uart_empty_o  out  1  FIFO empty.
REQ-013 SHALL provide uart_level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 SHALL provide uart_ovf_o  out  1  sticky overflow, write lost while full.
REQ-015 SHALL provide uart_busy  out  1  frame in progress or FIFO non-empty.
REQ-016 SHALL provide uart_tx  out  1  serial line, idle high, registered output.

Function
REQ-017 Write SHALL be accepted on an edge where uart_wr_i=1 and uart_full_o=0 (pre-edge value); the entry SHALL be visible one cycle later.
REQ-018 Write while full SHALL be dropped, SHALL set uart_ovf_o, and SHALL leave FIFO unchanged, even if a pop occurs on the same edge.
REQ-019 Simultaneous accepted write and pop SHALL leave uart_level_o unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE: uart_tx=1; on an edge with FIFO non-empty SHALL pop head into shift register, latch baud_div_i, enter START.
REQ-022 Each state bit SHALL last exactly baud_div_i+1 clocks (value latched at frame start; 0 gives 1-clock bits); mid-frame changes of baud_div_i SHALL be ignored.
REQ-023 START SHALL drive uart_tx=0 for one bit period, then DATA.
REQ-024 DATA SHALL send DATA_WIDTH bits LSB first, then PARITY if PARITY_MODE!=0, else STOP.
REQ-025 PARITY bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-026 STOP SHALL drive uart_tx=1 for STOP_BITS bit periods; at its end SHALL pop and enter START on the same edge if FIFO non-empty (no idle gap), else enter IDLE.
REQ-027 uart_busy SHALL equal (state!=IDLE) or !uart_empty_o.
REQ-028 uart_full_o, uart_empty_o, uart_level_o SHALL reflect registered FIFO state with no combinational path from uart_wr_i.

Reset
REQ-029 Asserting sys_rst_i low SHALL immediately force: uart_tx=1, state IDLE, FIFO empty (level 0, empty=1, full=0), uart_ovf_o=0, uart_busy=0, baud counter 0.
REQ-030 Reset mid-frame SHALL abort the frame and discard all FIFO contents; the first frame after release SHALL start only after a new write.
REQ-031 Release SHALL be sampled synchronously; first write SHALL be accepted on the first rising edge after release.

Verification
REQ-032 8N1, baud_div_i=3, write 0xA5 -> uart_tx low 2 edges after write edge, then bits 0,1,0,1,0,0,1,0,1,1 each 4 clocks, 40 clocks total, busy falls after stop.
REQ-033 PARITY_MODE=1, baud_div_i=0, write 0xA5 -> parity bit 0; PARITY_MODE=2 -> parity bit 1; frame 11 clocks.
REQ-034 baud_div_i=100, 18 back-to-back writes -> 17 accepted (first popped immediately), level 16, full=1, ovf=1, byte 18 never transmitted.
REQ-035 Write 0x01,0x02,0x03 consecutively, baud_div_i=1 -> three contiguous frames, stop bit of each directly followed by next start bit, empty=1 after third pop.
REQ-036 Reset low during DATA bit 3 with 5 entries queued -> uart_tx=1 same cycle, level 0, ovf 0, line stays high after release until new write.
REQ-037 STOP_BITS=2, baud_div_i=2, write 0xFF -> stop high 6 clocks before next start or idle.
